uart_tx_fifo: RTL and testbench

Transmit path of the keyboard-controller UART: a byte FIFO plus an 8N1 serializer with its own baud divider. It sits directly downstream of the CPU bus synchroniser and consumes the one-cycle write strobe and write byte that the bus layer produces for the TX data register. It drives the TxD pin, FIFO status bits and an active-low interrupt back toward the register block.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_byte_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the keyboard-controller UART transmit path.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DATA_BITS       = 8;
  localparam int DEFAULT_DIVISOR = 434;
endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with first-word-fall-through read (dout always shows the head).
// Latency: a pushed byte is visible on dout and counted in level one cycle after the push edge.
// Backpressure: a push while full and a pop while empty are both ignored; the caller watches full.
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);
  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // full/empty come from the registered level, so a same-edge pop never frees room for a push.
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit path: byte FIFO feeding an 8N1 serializer with its own baud divider.
// Latency: a byte written into an empty FIFO while idle starts its start bit one edge later.
// Backpressure: none upstream; writes while full are dropped and flagged in the sticky ovf bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIVISOR    = DEFAULT_DIVISOR,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  irq_en,
  input  logic                  ovf_clr,
  output logic                  txd,
  output logic                  busy,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  irq_n
);
  localparam logic [15:0] RELOAD   = 16'(DIVISOR - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t   state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  fifo_dout;
  logic        expired;
  logic        fifo_pop;

  assign busy    = (state != IDLE);
  assign expired = (baud_cnt == '0);
  // Pop exactly when the FSM loads a new frame: from IDLE, or at stop-bit expiry for back-to-back.
  assign fifo_pop = ~empty & ((state == IDLE) | ((state == STOP) & expired));

  uart_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shift    <= fifo_dout;
            txd      <= 1'b0;
            baud_cnt <= RELOAD;
            state    <= START;
          end
        end
        START: begin
          if (expired) begin
            txd      <= shift[0];
            bit_cnt  <= '0;
            baud_cnt <= RELOAD;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (expired) begin
            baud_cnt <= RELOAD;
            if (bit_cnt == LAST_BIT) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (expired) begin
            if (!empty) begin
              shift    <= fifo_dout;
              txd      <= 1'b0;
              baud_cnt <= RELOAD;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Dropped write beats a same-edge clear so no overflow event is ever lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf   <= 1'b0;
      irq_n <= 1'b1;
    end else begin
      if (wr_en & full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      irq_n <= ~(irq_en & empty & ~busy);
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a cycle-vector table for the first frame plus hand sequences.
module tb_uart_tx_fifo;
  localparam int DIV = 4;
  localparam int DL2 = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       irq_en = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       txd, busy, empty, full, ovf, irq_n;
  logic [DL2:0] level;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DIVISOR(DIV), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .irq_en(irq_en),
    .ovf_clr(ovf_clr), .txd(txd), .busy(busy), .empty(empty), .full(full),
    .level(level), .ovf(ovf), .irq_n(irq_n)
  );

  typedef struct packed {
    logic       txd;
    logic       busy;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       ovf;
    logic       irq_n;
  } obs_t;

  typedef struct {
    logic       rst_n;
    logic       wr;
    logic [7:0] data;
    obs_t       exp;
  } vec_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         max_lvl = 0;
  int         frame_err = 0;
  vec_t       vecs[$];
  vec_t       v;
  logic [9:0] frame_a5;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         rx_start_q[$];
  bit         rx_on = 1'b0;
  int         rx_ph = 0;
  logic [7:0] rx_b = 8'h00;
  bit         saw_low = 1'b0;

  function automatic obs_t mk(logic t, logic b, logic e, logic f, logic [4:0] l, logic o, logic i);
    return {t, b, e, f, l, o, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(level) > max_lvl) max_lvl = int'(level);
  endtask

  task automatic check_val(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(string name, obs_t exp);
    obs_t act;
    act = {txd, busy, empty, full, 5'(level), ovf, irq_n};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got txd/busy/empty/full/level/ovf/irq_n=%b/%b/%b/%b/%0d/%b/%b, want %b/%b/%b/%b/%0d/%b/%b",
               name, act.txd, act.busy, act.empty, act.full, act.level, act.ovf, act.irq_n,
               exp.txd, exp.busy, exp.empty, exp.full, exp.level, exp.ovf, exp.irq_n);
    end
  endtask

  task automatic check_rx(string name);
    check_val({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      check_val($sformatf("%s_byte%0d", name, i), int'(rx_q[i]), int'(exp_q[i]));
    end
    rx_q.delete();
    exp_q.delete();
    rx_start_q.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Receiver model: sample mid-bit on the falling edge, LSB first, abort on reset.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on = 1'b1;
        rx_ph = 0;
        rx_start_q.push_back(cyc);
      end
    end else begin
      rx_ph++;
      if (rx_ph == DIV / 2) begin
        if (txd !== 1'b0) frame_err++;
      end else if (rx_ph > DIV && rx_ph < 9 * DIV && (rx_ph % DIV) == DIV / 2) begin
        rx_b = {txd, rx_b[7:1]};
      end else if (rx_ph == 9 * DIV + DIV / 2) begin
        if (txd !== 1'b1) frame_err++;
        rx_q.push_back(rx_b);
        rx_on = 1'b0;
      end
    end
  end

  initial begin
    // 0xA5 framed LSB first: start, 1,0,1,0,0,1,0,1, stop (bit i = frame slot i).
    frame_a5 = 10'b1101001010;

    v.rst_n = 1'b0; v.wr = 1'b1; v.data = 8'h55; v.exp = mk(1, 0, 1, 0, 0, 0, 1); vecs.push_back(v);
    v.rst_n = 1'b1; v.wr = 1'b0; v.data = 8'h00; v.exp = mk(1, 0, 1, 0, 0, 0, 0); vecs.push_back(v);
    v.rst_n = 1'b1; v.wr = 1'b1; v.data = 8'hA5; v.exp = mk(1, 0, 0, 0, 1, 0, 0); vecs.push_back(v);
    v.rst_n = 1'b1; v.wr = 1'b0; v.data = 8'h00; v.exp = mk(0, 1, 1, 0, 0, 0, 1); vecs.push_back(v);
    for (int k = 1; k <= 41; k++) begin
      v.rst_n = 1'b1; v.wr = 1'b0; v.data = 8'h00;
      v.exp = mk((k < 40) ? frame_a5[k / 4] : 1'b1, k < 40, 1, 0, 0, 0, k < 41);
      vecs.push_back(v);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst_n;
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].data;
      tick();
      check_obs($sformatf("a5_vec%0d", i), vecs[i].exp);
    end
    reset = 1'b1;
    wr_en = 1'b0;
    exp_q.push_back(8'hA5);
    check_rx("a5_rx");

    // Three writes on consecutive cycles must go out as contiguous frames.
    max_lvl = 0;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = exp_q[i];
      tick();
    end
    wr_en = 1'b0;
    repeat (130) tick();
    check_val("b2b_level_peak", max_lvl, 2);
    check_val("b2b_frames", rx_start_q.size(), 3);
    if (rx_start_q.size() == 3) begin
      check_val("b2b_gap1", rx_start_q[1] - rx_start_q[0], 10 * DIV);
      check_val("b2b_gap2", rx_start_q[2] - rx_start_q[1], 10 * DIV);
    end
    check_rx("b2b_rx");

    // 18 writes in a row: 17 fit (one goes straight to the shifter), the 18th overflows.
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h10 + 8'(i);
      if (i < 17) exp_q.push_back(8'h10 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    check_val("ovf_set", int'(ovf), 1);
    check_val("ovf_level", int'(level), 16);
    check_val("ovf_full", int'(full), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_val("ovf_clr", int'(ovf), 0);
    repeat (700) tick();
    check_rx("ovf_rx");

    // Full FIFO with a write on the very edge the FSM pops for back-to-back.
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h60 + 8'(i);
      exp_q.push_back(8'h60 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    repeat (24) tick();
    check_val("popedge_pre_level", int'(level), 16);
    check_val("popedge_pre_ovf", int'(ovf), 0);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check_val("popedge_ovf", int'(ovf), 1);
    check_val("popedge_level", int'(level), 15);
    check_val("popedge_full", int'(full), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    repeat (680) tick();
    check_rx("popedge_rx");

    // Reset during data bit 3 of 0x81 with a second byte queued.
    wr_en = 1'b1; wr_data = 8'h81; tick();
    wr_en = 1'b1; wr_data = 8'h42; tick();
    wr_en = 1'b0;
    repeat (17) tick();
    check_val("rst_pre_txd", int'(txd), 0);
    check_val("rst_pre_level", int'(level), 1);
    reset = 1'b0;
    tick();
    check_obs("rst_state", mk(1, 0, 1, 0, 0, 0, 1));
    tick();
    reset = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    check_val("rst_txd_quiet", int'(saw_low), 0);
    check_val("rst_no_frame", rx_q.size(), 0);
    rx_q.delete();
    rx_start_q.delete();

    // 40 spaced writes walk both pointers around the ring more than twice.
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i * 37 + 5);
      exp_q.push_back(8'(i * 37 + 5));
      tick();
      wr_en = 1'b0;
      repeat (41) tick();
    end
    repeat (5) tick();
    check_val("wrap_level_max", max_lvl, 1);
    check_rx("wrap_rx");

    check_val("framing_errors", frame_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
